mips_dmem: RTL and testbench
============================

# mips_dmem

Data-memory responder for the pipelined MIPS core: answers the core's Memory-stage access port (MemWriteM, ALUOutM, WriteDataM, ReadDataM). Word-organised RAM with combinational read and synchronous write, plus an optional memory-mapped I/O page (free-running timer, test-completion "tohost" register, sticky access-error status). Sits beside the core at the top level, opposite the core's data-memory initiator port.

## Interface
- ADDR_W, 8, RAM word-address width; RAM holds 2^ADDR_W 32-bit words (byte range 0 .. 2^(ADDR_W+2)-1)
- MMIO_BASE, 32'hFFFF_0000, base byte address of the 16-byte MMIO page
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- MemWriteM  input  1  write strobe for the current access
- ALUOutM  input  32  byte address of the current access
- WriteDataM  input  32  store data
- ReadDataM  output  32  load data, combinational from ALUOutM and current state
- halt  output  1  sticky; set by first TOHOST write
- tohost  output  32  value captured by first TOHOST write
- err  output  1  sticky access-error flag

## Operation
- One access per cycle; every cycle is an access (read when MemWriteM=0).
- Decode on ALUOutM: RAM if ALUOutM[31:ADDR_W+2]==0; MMIO if ALUOutM[31:4]==MMIO_BASE[31:4] and MMIO compiled in; otherwise out-of-range.
- RAM word index = ALUOutM[ADDR_W+1:2].
- Misaligned (ALUOutM[1:0]!=0): write dropped, err set; read returns word at truncated index, err not set.
- Out-of-range: write dropped, err set; read returns 0, err not set.
- MMIO registers (offset = ALUOutM[3:0]):
  - 0x0 TIMER: read returns 32-bit counter; writes ignored.
  - 0x4 TOHOST: write with halt=0 captures WriteDataM into tohost and sets halt; writes with halt=1 ignored; read returns tohost.
  - 0x8 ERRSTAT: read returns {31'b0, err}; any write clears err.
  - 0xC reserved: read 0, write ignored, no err.
- RAM contents: not affected by reset; initialised only by the bench.
- RAM writes remain accepted after halt.

## Timing
- Read latency 0: ReadDataM valid in the same cycle as ALUOutM.
- Writes take effect at the rising edge ending the cycle with MemWriteM=1.
- Same-address write then read: read in the write cycle returns old data; following cycle returns new data.
- TIMER: 0 on reset, +1 every cycle, wraps 32'hFFFF_FFFF -> 0; read returns pre-edge value.
- Reset values: halt=0, tohost=0, err=0, TIMER=0. ReadDataM forced to 0 while reset=1.
- All writes, including RAM and MMIO, suppressed in any cycle with reset=1; reset mid-run discards that cycle's write.
- err set and ERRSTAT clear cannot coincide (one access per cycle); err stays 1 until an ERRSTAT write or reset.

## Configuration
- DMEM_MMIO_EN defined: MMIO page, TIMER, TOHOST, and ERRSTAT present as above; err also reported via ERRSTAT.
- DMEM_MMIO_EN undefined: no MMIO decode; MMIO_BASE addresses are out-of-range and follow out-of-range rules. halt and tohost are tied to 0; there is no timer. err remains present but is clearable only by reset.

## Test plan
- Reset, write 32'hDEADBEEF to 0x10, then read 0x10 -> old value in the write cycle, 32'hDEADBEEF in the next cycle; err=0.
- Write 32'h1234 to 0x13 (misaligned) -> RAM word 4 unchanged, err=1. Then write any value to MMIO_BASE+8 -> err=0 next cycle.
- Write to 0x0001_0000 with ADDR_W=8 -> dropped, err=1; read 0x0001_0000 -> ReadDataM=0.
- With DMEM_MMIO_EN: hold reset 3 cycles, release, read MMIO_BASE+0 on cycle 5 after release -> 5; preload counter near wrap via force -> wraps to 0.
- With DMEM_MMIO_EN: write 32'h1 to MMIO_BASE+4, then 32'h2 -> halt=1, tohost=32'h1, read returns 1; assert reset -> halt=0, tohost=0.
- Without DMEM_MMIO_EN: write MMIO_BASE+4 -> halt stays 0, err=1; read MMIO_BASE+0 -> 0.

Source files
------------

// File: rtl/mips_dmem.sv
// Data-memory responder for the pipelined MIPS core: word RAM plus an optional MMIO page
// (TIMER / TOHOST / ERRSTAT) compiled in when DMEM_MMIO_EN is defined.
module mips_dmem #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        halt,
    output logic [31:0] tohost,
    output logic        err
);

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] wordIdx;
    logic              isRam;
    logic              isMmio;
    logic              misaligned;
    logic              accWe;
    logic              badWrite;
    logic              ramWe;
    logic              errClr;

    assign isRam      = (ALUOutM[31:ADDR_W+2] == '0);
    assign wordIdx    = ALUOutM[ADDR_W+1:2];
    assign misaligned = |ALUOutM[1:0];
    assign accWe      = MemWriteM && !reset;

`ifdef DMEM_MMIO_EN
    logic [31:0] timer;
    logic        mmioWe;

    assign isMmio = (ALUOutM[31:4] == MMIO_BASE[31:4]);
    assign mmioWe = accWe && isMmio && !misaligned;
    assign errClr = mmioWe && (ALUOutM[3:2] == 2'd2);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer  <= '0;
            halt   <= 1'b0;
            tohost <= '0;
        end else begin
            timer <= timer + 32'd1;
            // Only the first TOHOST store is kept; later ones leave the result frozen.
            if (mmioWe && ALUOutM[3:2] == 2'd1 && !halt) begin
                tohost <= WriteDataM;
                halt   <= 1'b1;
            end
        end
    end
`else
    assign isMmio = 1'b0;
    assign errClr = 1'b0;
    assign halt   = 1'b0;
    assign tohost = '0;
`endif

    // Misaligned stores and stores outside every region are dropped and flagged.
    assign badWrite = accWe && (misaligned || (!isRam && !isMmio));
    assign ramWe    = accWe && isRam && !misaligned;

    // NOTE: the RAM array has no reset; its contents survive reset and are loaded by software.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            mem[wordIdx] <= WriteDataM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (badWrite) begin
            err <= 1'b1;
        end else if (errClr) begin
            err <= 1'b0;
        end
    end

    // NOTE: ReadDataM gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        ReadDataM = '0;
        if (!reset) begin
            if (isRam) begin
                ReadDataM = mem[wordIdx];
            end
`ifdef DMEM_MMIO_EN
            else if (isMmio) begin
                case (ALUOutM[3:2])
                    2'd0:    ReadDataM = timer;
                    2'd1:    ReadDataM = tohost;
                    2'd2:    ReadDataM = {31'b0, err};
                    default: ReadDataM = '0;
                endcase
            end
`endif
        end
    end

endmodule

// File: tb/tb_mips_dmem.sv
// Self-checking bench for mips_dmem: a byte-address-level memory/MMIO model checked every cycle,
// plus literal expectations for the key scenarios. Honours DMEM_MMIO_EN like the design.
module tb_mips_dmem;

    localparam int          ADDR_W    = 8;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
    localparam logic [31:0] RAM_BYTES = 32'd4 << ADDR_W;
    localparam int          NWORDS    = 2**ADDR_W;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        halt;
    logic [31:0] tohost;
    logic        err;

    always #5 clk = ~clk;

    mips_dmem #(.ADDR_W(ADDR_W), .MMIO_BASE(MMIO_BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .halt       (halt),
        .tohost     (tohost),
        .err        (err)
    );

    // Reference model state
    logic [31:0] mMem   [NWORDS];
    bit          mKnown [NWORDS];
    bit          mErr;
    bit          mHalt;
    logic [31:0] mTohost;
    logic [31:0] mTimer;

    int          nPass  = 0;
    int          nTotal = 0;
    logic [31:0] lastRead;
    logic        lastErr;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nTotal++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic bit inMmio(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
        return (a >= MMIO_BASE) && (a < MMIO_BASE + 32'd16);
`else
        return (a == 32'd0) && (a != 32'd0);
`endif
    endfunction

    // Expected load value; returns 0 when the RAM word has never been written.
    function automatic bit expRead(input logic [31:0] a, output logic [31:0] v);
        int idx;
        v = '0;
        if (reset) return 1'b1;
        if (a < RAM_BYTES) begin
            idx = int'(a / 32'd4);
            v = mMem[idx];
            return mKnown[idx];
        end
        if (inMmio(a)) begin
            case ((a - MMIO_BASE) / 32'd4)
                32'd0:   v = mTimer;
                32'd1:   v = mTohost;
                32'd2:   v = {31'b0, mErr};
                default: v = '0;
            endcase
        end
        return 1'b1;
    endfunction

    task automatic modelEdge(input logic rst, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (rst) begin
            mErr = 0; mHalt = 0; mTohost = '0; mTimer = '0;
            return;
        end
        mTimer = mTimer + 32'd1;
        if (!we) return;
        if (a % 32'd4 != 0) mErr = 1;
        else if (a < RAM_BYTES) begin
            mMem[int'(a / 32'd4)]   = d;
            mKnown[int'(a / 32'd4)] = 1;
        end else if (inMmio(a)) begin
            if (a - MMIO_BASE == 32'd4 && !mHalt) begin
                mTohost = d;
                mHalt   = 1;
            end else if (a - MMIO_BASE == 32'd8) mErr = 0;
        end else mErr = 1;
    endtask

    // One access cycle: drive at the falling edge, compare mid-low phase, advance model at the rising edge.
    task automatic cycle(input logic rst, input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ev;
        bit          known;
        reset = rst; MemWriteM = we; ALUOutM = a; WriteDataM = d;
        #1;
        known = expRead(a, ev);
        if (known) check("ReadDataM", ReadDataM, ev);
        check("err", {31'b0, err}, {31'b0, mErr});
        check("halt", {31'b0, halt}, {31'b0, mHalt});
        check("tohost", tohost, mTohost);
        lastRead = ReadDataM;
        lastErr  = err;
        @(posedge clk);
        modelEdge(rst, we, a, d);
        @(negedge clk);
    endtask

    task automatic clearErr();
`ifdef DMEM_MMIO_EN
        cycle(1'b0, 1'b1, MMIO_BASE + 32'd8, 32'h0);
`else
        cycle(1'b1, 1'b0, 32'h0, 32'h0);
`endif
    endtask

    logic [31:0] mixAddr [8] = '{32'h0, 32'h4, 32'h80, 32'h84, 32'h200, 32'h3F8, 32'h3FC, 32'h100};

    initial begin
        for (int i = 0; i < NWORDS; i++) begin
            mKnown[i] = 0;
            mMem[i]   = '0;
        end
        mErr = 0; mHalt = 0; mTohost = '0; mTimer = '0;

        cycle(1'b1, 1'b0, 32'h10, 32'h0);
        check("reset read", lastRead, 32'h0);
        cycle(1'b1, 1'b1, 32'h10, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0);
        check("reset err", {31'b0, lastErr}, 32'h0);

        for (int i = 0; i < NWORDS; i++) cycle(1'b0, 1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i));

        // Write-then-read ordering
        cycle(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        check("wr cycle old", lastRead, 32'h1000_0004);
        cycle(1'b0, 1'b0, 32'h10, 32'h0);
        check("rd new", lastRead, 32'hDEAD_BEEF);
        check("no err", {31'b0, lastErr}, 32'h0);

        // Misaligned store dropped, misaligned load truncates
        cycle(1'b0, 1'b1, 32'h13, 32'h1234);
        cycle(1'b0, 1'b0, 32'h13, 32'h0);
        check("misalign rd", lastRead, 32'hDEAD_BEEF);
        check("misalign err", {31'b0, lastErr}, 32'h1);
        clearErr();
        cycle(1'b0, 1'b0, 32'h10, 32'h0);
        check("err cleared", {31'b0, lastErr}, 32'h0);

        // Out-of-range
        cycle(1'b0, 1'b1, 32'h0001_0000, 32'h77);
        cycle(1'b0, 1'b0, 32'h0001_0000, 32'h0);
        check("oor rd", lastRead, 32'h0);
        check("oor err", {31'b0, lastErr}, 32'h1);
        clearErr();

        // RAM boundary
        cycle(1'b0, 1'b1, 32'h3FC, 32'hCAFE_F00D);
        cycle(1'b0, 1'b0, 32'h3FC, 32'h0);
        check("top word", lastRead, 32'hCAFE_F00D);
        cycle(1'b0, 1'b1, 32'h400, 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 32'h0);
        check("word0 intact", lastRead, 32'h1000_0000);
        check("past top err", {31'b0, lastErr}, 32'h1);
        clearErr();

        // Reset suppresses the concurrent write
        cycle(1'b1, 1'b1, 32'h20, 32'hBAD0_BAD0);
        cycle(1'b0, 1'b0, 32'h20, 32'h0);
        check("rst drops wr", lastRead, 32'h1000_0008);

`ifdef DMEM_MMIO_EN
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 1'b0, MMIO_BASE, 32'h0);
        check("timer 5", lastRead, 32'h5);

        cycle(1'b0, 1'b1, MMIO_BASE + 32'd4, 32'h1);
        cycle(1'b0, 1'b1, MMIO_BASE + 32'd4, 32'h2);
        cycle(1'b0, 1'b0, MMIO_BASE + 32'd4, 32'h0);
        check("tohost rd", lastRead, 32'h1);
        check("tohost out", tohost, 32'h1);
        check("halt set", {31'b0, halt}, 32'h1);

        cycle(1'b0, 1'b1, 32'h40, 32'h5555_AAAA);
        cycle(1'b0, 1'b0, 32'h40, 32'h0);
        check("ram after halt", lastRead, 32'h5555_AAAA);

        cycle(1'b0, 1'b1, MMIO_BASE + 32'd12, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b0, MMIO_BASE + 32'd12, 32'h0);
        check("reserved rd", lastRead, 32'h0);
        check("reserved no err", {31'b0, lastErr}, 32'h0);

        cycle(1'b0, 1'b1, MMIO_BASE + 32'd1, 32'h0);
        cycle(1'b0, 1'b0, MMIO_BASE + 32'd8, 32'h0);
        check("errstat rd", lastRead, 32'h1);
        clearErr();

        force dut.timer = 32'hFFFF_FFFE;
        #1 release dut.timer;
        mTimer = 32'hFFFF_FFFE;
        cycle(1'b0, 1'b0, MMIO_BASE, 32'h0);
        cycle(1'b0, 1'b0, MMIO_BASE, 32'h0);
        check("timer max", lastRead, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b0, MMIO_BASE, 32'h0);
        check("timer wrap", lastRead, 32'h0);

        cycle(1'b1, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 1'b0, MMIO_BASE + 32'd4, 32'h0);
        check("halt rst", {31'b0, halt}, 32'h0);
        check("tohost rst", tohost, 32'h0);
`else
        cycle(1'b0, 1'b1, MMIO_BASE + 32'd4, 32'h1);
        cycle(1'b0, 1'b0, MMIO_BASE, 32'h0);
        check("no mmio rd", lastRead, 32'h0);
        check("no mmio halt", {31'b0, halt}, 32'h0);
        check("no mmio err", {31'b0, lastErr}, 32'h1);
        cycle(1'b0, 1'b1, MMIO_BASE + 32'd8, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0);
        check("err sticky", {31'b0, lastErr}, 32'h1);
        clearErr();
`endif

        // Mixed directed traffic, checked by the model each cycle
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, mixAddr[i], 32'hA000_0000 ^ (32'(i) << 8) ^ mixAddr[i]);
            cycle(1'b0, 1'b0, mixAddr[(i + 3) % 8], 32'h0);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, mixAddr[i], 32'h0);
        cycle(1'b0, 1'b0, 32'h200, 32'h0);
        check("mix literal", lastRead, 32'hA000_0000 ^ 32'h0000_0400 ^ 32'h200);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
